// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide, multiply-accumulate, and HI/LO move/read access.
`timescale 1ns/1ps
module iter_mdu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] mdu_out,
   output logic             rd_sel
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH:0]   eng, eng_step;
   logic [WIDTH-1:0]   opnd, hi, lo;
   logic               is_div, acc_add, acc_sub, neg_res, neg_rem, div_zero;

   logic               is_start, dec_div, dec_signed, dec_add, dec_sub, accept;
   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     shift_rem, diff, sum_hi;
   logic [2*WIDTH-1:0] prod_s, acc_res, result;
   logic [WIDTH-1:0]   quot_s, rem_s;

   always_comb begin
      is_start   = 1'b0;
      dec_div    = 1'b0;
      dec_signed = 1'b0;
      dec_add    = 1'b0;
      dec_sub    = 1'b0;
      case (op)
         OP_MULT:  begin is_start = 1'b1; dec_signed = 1'b1; end
         OP_MULTU: begin is_start = 1'b1; end
         OP_DIV:   begin is_start = 1'b1; dec_div = 1'b1; dec_signed = 1'b1; end
         OP_DIVU:  begin is_start = 1'b1; dec_div = 1'b1; end
         OP_MADD:  begin is_start = 1'b1; dec_signed = 1'b1; dec_add = 1'b1; end
         OP_MADDU: begin is_start = 1'b1; dec_add = 1'b1; end
         OP_MSUB:  begin is_start = 1'b1; dec_signed = 1'b1; dec_sub = 1'b1; end
         OP_MSUBU: begin is_start = 1'b1; dec_sub = 1'b1; end
         default:  ;
      endcase
   end

   assign sign_a = dec_signed & rs_data[WIDTH-1];
   assign sign_b = dec_signed & rt_data[WIDTH-1];
   assign mag_a  = cond_neg_w(rs_data, sign_a);
   assign mag_b  = cond_neg_w(rt_data, sign_b);

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         S_IDLE: begin
            if (is_start && !req) begin
               state_nx = S_RUN;
               accept   = 1'b1;
            end
         end
         S_RUN: begin
            if (req)                    state_nx = S_IDLE;
            else if (cnt == LAST_STEP)  state_nx = S_FINISH;
         end
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Engine layout: eng = {upper W+1 bits, lower W bits}. Multiply keeps the partial
   // product on top and shifts the multiplier out the bottom; divide keeps the
   // partial remainder on top and shifts quotient bits in at the bottom.
   always_comb begin
      shift_rem = {eng[2*WIDTH-1:WIDTH], eng[WIDTH-1]};
      diff      = shift_rem - {1'b0, opnd};
      sum_hi    = eng[2*WIDTH:WIDTH] + (eng[0] ? {1'b0, opnd} : '0);
      if (is_div)
         eng_step = diff[WIDTH] ? {shift_rem, eng[WIDTH-2:0], 1'b0}
                                : {diff, eng[WIDTH-2:0], 1'b1};
      else
         eng_step = {1'b0, sum_hi, eng[WIDTH-1:1]};
   end

   always_comb begin
      prod_s = cond_neg_2w(eng[2*WIDTH-1:0], neg_res);
      if (acc_add)      acc_res = {hi, lo} + prod_s;
      else if (acc_sub) acc_res = {hi, lo} - prod_s;
      else              acc_res = prod_s;
      quot_s = cond_neg_w(eng[WIDTH-1:0], neg_res);
      rem_s  = cond_neg_w(eng[2*WIDTH-1:WIDTH], neg_rem);
      result = is_div ? {rem_s, quot_s} : acc_res;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (state == S_RUN && !req) ? cnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eng      <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         acc_add  <= 1'b0;
         acc_sub  <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
      end else if (accept) begin
         opnd     <= dec_div ? mag_b : mag_a;
         eng      <= {{(WIDTH+1){1'b0}}, (dec_div ? mag_a : mag_b)};
         is_div   <= dec_div;
         acc_add  <= dec_add;
         acc_sub  <= dec_sub;
         neg_res  <= sign_a ^ sign_b;
         neg_rem  <= sign_a;
         div_zero <= dec_div && (rt_data == '0);
      end else if (state == S_RUN && !req) begin
         eng <= eng_step;
      end
   end

   // A divide by zero still runs the full sequence but leaves HI/LO untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == S_IDLE && !req) begin
         if (op == OP_MTHI) hi <= rs_data;
         if (op == OP_MTLO) lo <= rs_data;
      end else if (state == S_FINISH && !req && !(is_div && div_zero)) begin
         hi <= result[2*WIDTH-1:WIDTH];
         lo <= result[WIDTH-1:0];
      end
   end

   assign busy    = is_start | (state != S_IDLE);
   assign done    = (state == S_FINISH) && !req;
   assign rd_sel  = (op == OP_MFHI) || (op == OP_MFLO);
   assign mdu_out = (op == OP_MFHI) ? hi : (op == OP_MFLO) ? lo : '0;

endmodule

// File: tb/tb_iter_mdu.sv
// Bench for iter_mdu: vector table with a result scoreboard, plus hand-written
// sequences for cancel, reset, stall and back-to-back behaviour.
`timescale 1ns/1ps
module tb_iter_mdu;

   localparam int W = 32;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   logic         clk = 1'b0;
   logic         reset;
   logic         req;
   logic [3:0]   op;
   logic [W-1:0] rs_data, rt_data;
   logic         busy, done, rd_sel;
   logic [W-1:0] mdu_out;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
   } vec_t;

   vec_t vecs[17];

   iter_mdu #(.WIDTH(W), .CNT_W(6)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .done    (done),
      .mdu_out (mdu_out),
      .rd_sel  (rd_sel)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
      op = OP_MTHI; rs_data = h; tick();
      op = OP_MTLO; rs_data = l; tick();
      op = OP_NONE;
   endtask

   task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
      op = OP_MFHI; #1; h = mdu_out;
      op = OP_MFLO; #1; l = mdu_out;
      op = OP_NONE; #1;
   endtask

   // Called in cycle start_cyc after the accept edge; all earlier cycles were busy.
   task automatic wait_finish(input string name, input int start_cyc);
      int cyc;
      int busy_n;
      logic [W-1:0] h, l;
      cyc    = start_cyc;
      busy_n = start_cyc;
      while (!done && cyc < 200) begin
         if (busy) busy_n++;
         tick();
         cyc++;
      end
      check({name, " done_cycle"}, 64'(cyc), 64'd33);
      if (busy) busy_n++;
      check({name, " busy_cycles"}, 64'(busy_n), 64'd34);
      tick();
      check({name, " busy_after"}, 64'(busy), 64'd0);
      read_hilo(h, l);
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s hilo: got %h_%h with no expected entry queued", name, h, l);
      end else begin
         logic [63:0] e;
         e = exp_q.pop_front();
         if ({h, l} !== e) begin
            errors++;
            $display("FAIL %s hilo: got %h_%h expected %h", name, h, l, e);
         end
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] e);
      exp_q.push_back(e);
      op = o; rs_data = a; rt_data = b;
      tick();
      op = OP_NONE; rs_data = $urandom; rt_data = $urandom;
      wait_finish(name, 1);
   endtask

   initial begin
      logic [W-1:0] h, l;
      int done_seen;
      int cyc;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,        32'hFFFFFFFE, 32'h00000001};
      vecs[2]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h0,  32'h0,        32'h00000002, 32'h0000000E};
      vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,  32'h0,        32'h00000000, 32'h80000000};
      vecs[5]  = '{OP_MADDU, 32'h00000001, 32'h00000001, 32'h1,  32'hFFFFFFFF, 32'h00000002, 32'h00000000};
      vecs[6]  = '{OP_MSUB,  32'h00000001, 32'h00000001, 32'h2,  32'h0,        32'h00000001, 32'hFFFFFFFF};
      vecs[7]  = '{OP_DIVU,  32'h00000123, 32'h00000000, 32'hAA, 32'hBB,       32'h000000AA, 32'h000000BB};
      vecs[8]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,  32'h0,        32'h00000001, 32'hFFFFFFFD};
      vecs[10] = '{OP_MADD,  32'hFFFFFFFE, 32'h00000003, 32'h0,  32'h10,       32'h00000000, 32'h0000000A};
      vecs[11] = '{OP_MSUBU, 32'h00000001, 32'h00000002, 32'h0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[12] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h0,  32'h0,        32'h00000001, 32'h00000000};
      vecs[13] = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h12, 32'h34,       32'h00000012, 32'h00000034};
      vecs[14] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h0,  32'h0,        32'h00000000, 32'hFFFFFFFF};
      vecs[15] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,        32'h40000000, 32'h00000000};
      vecs[16] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0,  32'h0,        32'hFFFFFFFF, 32'h00000003};

      reset = 1'b0; req = 1'b0; op = OP_NONE; rs_data = '0; rt_data = '0;
      tick(); tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("idle mdu_out", 64'(mdu_out), 64'd0);
      check("idle rd_sel", 64'(rd_sel), 64'd0);
      op = OP_MFHI; #1;
      check("mfhi rd_sel", 64'(rd_sel), 64'd1);
      read_hilo(h, l);
      check("reset hilo", {h, l}, 64'd0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                {vecs[i].exp_hi, vecs[i].exp_lo});
      end

      // Back-to-back: second op presented in the cycle right after FINISH.
      write_hilo(32'h0, 32'h0);
      run_op("b2b first", OP_MULTU, 32'd3, 32'd4, 64'd12);
      run_op("b2b second", OP_MULTU, 32'd5, 32'd6, 64'd30);

      // Ops presented while running are ignored; mfhi still reads the old HI.
      write_hilo(32'h100, 32'h200);
      exp_q.push_back(64'd6);
      op = OP_MULT; rs_data = 32'd2; rt_data = 32'd3; tick();
      op = OP_MTHI; rs_data = 32'hDEAD; tick();
      op = OP_MULTU; rs_data = 32'd9; rt_data = 32'd9; tick();
      op = OP_MFHI; #1;
      check("stall stale hi", 64'(mdu_out), 64'h100);
      check("stall busy", 64'(busy), 64'd1);
      op = OP_NONE;
      wait_finish("stall", 3);

      // req during RUN cycle 10 cancels; a new op starts the very next cycle.
      write_hilo(32'h11, 32'h22);
      op = OP_MULT; rs_data = 32'd3; rt_data = 32'd3; tick();
      op = OP_NONE;
      for (int i = 0; i < 9; i++) tick();
      req = 1'b1; #1;
      check("cancel done", 64'(done), 64'd0);
      tick();
      req = 1'b0; #1;
      check("cancel busy", 64'(busy), 64'd0);
      read_hilo(h, l);
      check("cancel hilo", {h, l}, {32'h11, 32'h22});
      run_op("after cancel", OP_MULT, 32'd4, 32'd5, 64'd20);

      // req in IDLE blocks mthi and starts, but busy follows the op decode.
      write_hilo(32'h11, 32'h22);
      req = 1'b1; op = OP_MTHI; rs_data = 32'hFFFF; tick();
      op = OP_MULT; rs_data = 32'd2; rt_data = 32'd2; #1;
      check("idle req busy decode", 64'(busy), 64'd1);
      tick();
      op = OP_NONE; req = 1'b0; #1;
      check("idle req no start", 64'(busy), 64'd0);
      read_hilo(h, l);
      check("idle req hilo", {h, l}, {32'h11, 32'h22});

      // req in FINISH suppresses done and the HI/LO write.
      write_hilo(32'h33, 32'h44);
      op = OP_MULT; rs_data = 32'd5; rt_data = 32'd5; tick();
      op = OP_NONE;
      cyc = 1;
      while (!done && cyc < 200) begin tick(); cyc++; end
      check("finish req cycle", 64'(cyc), 64'd33);
      req = 1'b1; #1;
      check("finish req done", 64'(done), 64'd0);
      tick();
      req = 1'b0; #1;
      check("finish req busy", 64'(busy), 64'd0);
      read_hilo(h, l);
      check("finish req hilo", {h, l}, {32'h33, 32'h44});

      // Asynchronous reset mid-run clears everything at once, no later done.
      write_hilo(32'h55, 32'h66);
      op = OP_MULT; rs_data = 32'd7; rt_data = 32'd7; tick();
      op = OP_NONE;
      for (int i = 0; i < 4; i++) tick();
      #1; reset = 1'b0; #1;
      check("async reset busy", 64'(busy), 64'd0);
      read_hilo(h, l);
      check("async reset hilo", {h, l}, 64'd0);
      tick();
      reset = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) done_seen++;
         tick();
      end
      check("reset no done", 64'(done_seen), 64'd0);
      check("reset queue empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
